crypto_in_arb: RTL
==================

Name: crypto_in_arb

Overview:
- Packet-granular round-robin arbiter that shares the single crypto encrypt/decrypt pipeline between two NetFPGA-style 64-bit packet streams (e.g. host DMA path and MAC path).
- Sits directly upstream of the crypto block.
- Buffers each input in a small fall-through FIFO, grants one input per packet, and forwards that packet unbroken (module headers, Ethernet/IP header, payload) until EOP.

Parameters:
- DATA_WIDTH, 64, datapath width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bits per word.
- FIFO_DEPTH_BITS, 2, log2 depth of each input FIFO.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in0_data  input  DATA_WIDTH  stream 0 data.
- in0_ctrl  input  CTRL_WIDTH  stream 0 ctrl.
- in0_wr  input  1  stream 0 write strobe.
- in0_rdy  output  1  stream 0 may write.
- in1_data, in1_ctrl, in1_wr, in1_rdy  same as stream 0, for stream 1.
- out_data  output  DATA_WIDTH  to crypto in_data.
- out_ctrl  output  CTRL_WIDTH  to crypto in_ctrl.
- out_wr  output  1  to crypto in_wr.
- out_rdy  input  1  from crypto in_rdy.
- arb_grant  output  2  one-hot current owner; 0 when idle.
- pkt_cnt0  output  32  packets forwarded from stream 0 (feature-gated).
- pkt_cnt1  output  32  packets forwarded from stream 1 (feature-gated).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: state=IDLE; arb_grant=0; last_served=1, so input 0 wins first; out_wr=0; FIFOs empty; counters 0.
- Input handshake: inN_rdy = !fifoN_nearly_full. A word is accepted whenever inN_wr=1; the writer must respect inN_rdy.
- Word classification: a word is header/EOP when ctrl!=0 and data when ctrl==0.
- Output datapath:
  - out_data/out_ctrl are the granted FIFO head, combinational.
  - Both are 0 when arb_grant=0.
  - out_wr = (state!=IDLE) && !fifo_empty[grant] && out_rdy.
  - The FIFO read enable equals out_wr.
  - out_wr is never high while out_rdy is low.
- Latency: a word written at cycle N is visible at the FIFO head at N+1. Earliest out_wr for the first word of a packet is N+2, because of the IDLE arbitration cycle.
- State machine:
  - IDLE:
    - req = {!fifo1_empty, !fifo0_empty}.
    - If both request, grant the input != last_served. If one requests, grant it.
    - Register arb_grant and go to HDR. No word moves in this cycle.
  - HDR:
    - On each transfer, forward the word.
    - If ctrl==0, go to BODY. This also covers a packet with no module header.
  - BODY:
    - On each transfer, forward the word.
    - If ctrl!=0 (EOP): last_served<=grant, arb_grant<=0, increment the stream's counter, go to IDLE.
- Stalls: an empty granted FIFO or low out_rdy holds state. The grant is never revoked mid-packet, even if the other input is full.
- Fairness: a continuously requesting input waits at most one packet.
- Reset mid-packet: FIFOs are flushed and the partial packet is dropped. The next packet after reset starts in IDLE.
- Counters: 32-bit, wrap from 0xFFFFFFFF to 0.

Optional Feature:
- CRYPTO_ARB_STATS_EN defined: pkt_cnt0/pkt_cnt1 count as above.
- Undefined: the counter registers are not instantiated and pkt_cnt0/pkt_cnt1 are tied to 0. Ports remain present.

Decomposition:
- Shared package/defines:
  - State encodings: IDLE=1, HDR=2, BODY=4, one-hot, 3 bits.
  - Grant encodings: GNT_NONE=0, GNT_0=1, GNT_1=2.
  - Counter width 32.
- Input FIFOs reuse the existing fallthrough_small_fifo, width DATA_WIDTH+CTRL_WIDTH.
- One new sub-module, crypto_rr_pick:
  - Inputs: req[1:0], last_served.
  - Output: one-hot grant.
  - Purely combinational, so it can be unit-tested standalone.

Test Plan:
- Single packet on in0 (1 hdr ctrl=0xFF, 4 data ctrl=0, EOP ctrl=0x01), out_rdy=1 -> 6 identical words out in order, arb_grant=1 throughout, pkt_cnt0=1, then arb_grant=0.
- Both inputs present a 6-word packet in the same cycle -> in0 packet fully forwarded first, then in1. No interleaving, one idle cycle between packets.
- in0 streams 3 back-to-back packets while in1 has 1 pending -> order in0, in1, in0, in0.
- out_rdy held 0 for 5 cycles mid-BODY -> out_wr=0 during the stall, no word lost or duplicated, in0_rdy drops once its FIFO reaches nearly-full.
- reset asserted on the 3rd word of a packet -> next cycle arb_grant=0, FIFOs empty. A following clean in1 packet is forwarded intact with pkt_cnt1=1.
- With CRYPTO_ARB_STATS_EN, preload pkt_cnt0=0xFFFFFFFF via force and send 1 packet -> pkt_cnt0=0. Without the macro, pkt_cnt0 and pkt_cnt1 stay 0 for the whole test.

Source files
------------

// File: rtl/crypto_in_arb_pkg.sv
// crypto_in_arb_pkg: shared encodings for the crypto input arbiter.
//   state_t   : one-hot FSM encoding (IDLE=1, HDR=2, BODY=4)
//   GNT_*     : one-hot grant encodings, GNT_NONE when no input owns the output
//   CNT_WIDTH : width of the per-stream packet counters
package crypto_in_arb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      HDR  = 3'b010,
      BODY = 3'b100
   } state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_0    = 2'b01;
   localparam logic [1:0] GNT_1    = 2'b10;

   localparam int unsigned CNT_WIDTH = 32;

endpackage

// File: rtl/crypto_rr_pick.sv
// crypto_rr_pick: two-input round-robin pick, purely combinational.
// Ports:
//   req         : request per input, bit N = input N has a word waiting
//   last_served : index of the input that owned the previous packet
//   grant       : one-hot pick, GNT_NONE when nothing requests
module crypto_rr_pick
   import crypto_in_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] grant
);

   always_comb begin
      grant = GNT_NONE;
      unique case (req)
         2'b01:   grant = GNT_0;
         2'b10:   grant = GNT_1;
         // Contention: favour whoever did not own the last packet.
         2'b11:   grant = last_served ? GNT_0 : GNT_1;
         default: grant = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO. A word written on
// one edge is presented on dout right after that edge.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (flushes contents)
//   din, wr_en   : write data / strobe (writes while full are dropped)
//   rd_en        : pop the head word
//   dout         : head word, valid whenever empty is low
//   nearly_full  : at most one free slot left
//   empty        : no words stored
module fallthrough_small_fifo #(
   parameter int unsigned WIDTH          = 72,
   parameter int unsigned MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
   localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]             count_q;
   logic                      full, do_wr, do_rd;

   assign full        = (count_q == CW'(DEPTH));
   assign empty       = (count_q == '0);
   assign nearly_full = (count_q >= CW'(DEPTH - 1));
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign dout        = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; count_q gates visibility.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/crypto_in_arb.sv
// crypto_in_arb: packet-granular round-robin arbiter feeding the crypto pipeline
// from two 64-bit NetFPGA-style streams. Each input is buffered in a small
// fall-through FIFO; one input owns the output from its first word to its EOP.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   inN_data/ctrl/wr, inN_rdy : input streams 0/1, rdy = FIFO not nearly full
//   out_data/ctrl/wr, out_rdy : stream into the crypto block
//   arb_grant               : one-hot current owner, 0 while idle
//   pkt_cnt0, pkt_cnt1      : packets forwarded per stream
// Build option: define CRYPTO_ARB_STATS_EN to instantiate the packet counters;
// otherwise pkt_cnt0/pkt_cnt1 read 0.
module crypto_in_arb
   import crypto_in_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned FIFO_DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [CTRL_WIDTH-1:0] in0_ctrl,
   input  logic                  in0_wr,
   output logic                  in0_rdy,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic [CTRL_WIDTH-1:0] in1_ctrl,
   input  logic                  in1_wr,
   output logic                  in1_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic [1:0]            arb_grant,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

   localparam int unsigned FW = DATA_WIDTH + CTRL_WIDTH;

   logic [FW-1:0]         f_dout [2];
   logic [1:0]            f_empty, f_nearly_full, f_rd, req, pick;
   state_t                state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic                  last_q, last_d;
   logic                  gnt_idx, xfer, eop_xfer;
   logic [FW-1:0]         head;
   logic [CTRL_WIDTH-1:0] head_ctrl;

   fallthrough_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo0 (
      .clk         (clk),
      .reset       (reset),
      .din         ({in0_ctrl, in0_data}),
      .wr_en       (in0_wr),
      .rd_en       (f_rd[0]),
      .dout        (f_dout[0]),
      .nearly_full (f_nearly_full[0]),
      .empty       (f_empty[0])
   );

   fallthrough_small_fifo #(
      .WIDTH          (FW),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo1 (
      .clk         (clk),
      .reset       (reset),
      .din         ({in1_ctrl, in1_data}),
      .wr_en       (in1_wr),
      .rd_en       (f_rd[1]),
      .dout        (f_dout[1]),
      .nearly_full (f_nearly_full[1]),
      .empty       (f_empty[1])
   );

   assign in0_rdy = !f_nearly_full[0];
   assign in1_rdy = !f_nearly_full[1];
   assign req     = ~f_empty;

   crypto_rr_pick u_pick (
      .req         (req),
      .last_served (last_q),
      .grant       (pick)
   );

   // Grant is one-hot, so bit 1 alone selects the owning FIFO.
   assign gnt_idx   = grant_q[1];
   assign head      = f_dout[gnt_idx];
   assign head_ctrl = head[FW-1 -: CTRL_WIDTH];

   assign xfer      = (state_q != IDLE) && !f_empty[gnt_idx] && out_rdy;
   assign eop_xfer  = xfer && (head_ctrl != '0);
   assign f_rd[0]   = xfer && !gnt_idx;
   assign f_rd[1]   = xfer && gnt_idx;

   assign out_wr    = xfer;
   assign out_data  = (grant_q == GNT_NONE) ? '0 : head[DATA_WIDTH-1:0];
   assign out_ctrl  = (grant_q == GNT_NONE) ? '0 : head_ctrl;
   assign arb_grant = grant_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         // Arbitration cycle: latch the owner, nothing moves yet.
         IDLE: begin
            if (pick != GNT_NONE) begin
               grant_d = pick;
               state_d = HDR;
            end
         end
         // Module headers carry ctrl!=0; the first ctrl==0 word starts the body.
         HDR: begin
            if (xfer && (head_ctrl == '0)) state_d = BODY;
         end
         BODY: begin
            if (eop_xfer) begin
               last_d  = gnt_idx;
               grant_d = GNT_NONE;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = GNT_NONE;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= GNT_NONE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef CRYPTO_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else if ((state_q == BODY) && eop_xfer) begin
         if (gnt_idx) cnt1_q <= cnt1_q + 1'b1;
         else         cnt0_q <= cnt0_q + 1'b1;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule
